// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   hazardState_e : controller state (RUN, LOAD_STALL, FLUSH, MEM_WAIT)
//   REG_ZERO      : index of the hard-wired zero register (never stalls)
//   remWidth()    : width of the remaining-cycles down-counter
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } hazardState_e;

   localparam int unsigned REG_ZERO = 0;

   // Enough bits to hold the longest reload value of either sequence.
   function automatic int unsigned remWidth(input int unsigned loadStallCycles,
                                            input int unsigned flushSlots);
      int unsigned maxCycles;
      maxCycles = (loadStallCycles > flushSlots) ? loadStallCycles : flushSlots;
      return $clog2(maxCycles + 1);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the ID-stage pipeline and the hazard controller.
//   Pipeline -> controller : BranchControl, ID_EX_MemRead, ID_EX_RegisterRt,
//                            IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt,
//                            MemReq, MemReady
//   Controller -> pipeline : PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
//                            Freeze, StallCount, FlushCount
//   master = pipeline side, slave = hazard controller side.
interface hazard_control_unit_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
);

   logic                  BranchControl;
   logic                  ID_EX_MemRead;
   logic [REG_ADDR_W-1:0] ID_EX_RegisterRt;
   logic [REG_ADDR_W-1:0] IF_ID_RegisterRs;
   logic [REG_ADDR_W-1:0] IF_ID_RegisterRt;
   logic                  IF_ID_UsesRt;
   logic                  MemReq;
   logic                  MemReady;

   logic                  PCWrite;
   logic                  IF_ID_Write;
   logic                  ID_EX_Bubble;
   logic                  IF_ID_Flush;
   logic                  Freeze;
   logic [CNT_W-1:0]      StallCount;
   logic [CNT_W-1:0]      FlushCount;

   modport master (
      output BranchControl, ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs,
             IF_ID_RegisterRt, IF_ID_UsesRt, MemReq, MemReady,
      input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze,
             StallCount, FlushCount
   );

   modport slave (
      input  BranchControl, ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs,
             IF_ID_RegisterRt, IF_ID_UsesRt, MemReq, MemReady,
      output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze,
             StallCount, FlushCount
   );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter for performance debug; holds at all-ones.
//   clk, reset (async, active-high), inc : count enable, count : current value
module hazard_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller beside the ID stage: multi-cycle load-use stalls,
// multi-slot branch flushes and a full freeze while data memory is busy.
//   clk, reset (async, active-high)
//   hcu (slave) : hazard inputs from ID/EX, memory handshake, pipeline
//                 register controls and saturating stall/flush counters
// Control outputs are combinational from state and current inputs.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W        = 5,
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned FLUSH_SLOTS       = 1,
   parameter int unsigned CNT_W             = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_control_unit_if.slave hcu
);

   localparam int unsigned     REM_W        = remWidth(LOAD_STALL_CYCLES, FLUSH_SLOTS);
   localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_SLOTS - 1);
   localparam logic [REM_W-1:0] REM_ONE      = REM_W'(1);

   hazardState_e     state, stateNext;
   hazardState_e     shadowState, shadowStateNext;
   hazardState_e     effState;
   logic [REM_W-1:0] rem, remNext;
   logic [REM_W-1:0] shadowRem, shadowRemNext;
   logic [REM_W-1:0] effRem;
   logic             hazard;
   logic             memWait;
   logic             waiting;
   logic             stallInc;
   logic             flushInc;

   // Load-use on rs always, on rt only when the ID instruction reads it.
   assign hazard = hcu.ID_EX_MemRead
                && (hcu.ID_EX_RegisterRt != REG_ADDR_W'(REG_ZERO))
                && ((hcu.ID_EX_RegisterRt == hcu.IF_ID_RegisterRs)
                    || (hcu.IF_ID_UsesRt && (hcu.ID_EX_RegisterRt == hcu.IF_ID_RegisterRt)));

   // Once in MEM_WAIT only a completed access releases the freeze.
   assign memWait = hcu.MemReq && !hcu.MemReady;
   assign waiting = memWait || ((state == MEM_WAIT) && !hcu.MemReq);

   // Next state, counter enables and pipeline controls.
   always_comb begin
      hcu.PCWrite      = 1'b1;
      hcu.IF_ID_Write  = 1'b1;
      hcu.ID_EX_Bubble = 1'b0;
      hcu.IF_ID_Flush  = 1'b0;
      hcu.Freeze       = 1'b0;
      stateNext        = state;
      remNext          = rem;
      shadowStateNext  = shadowState;
      shadowRemNext    = shadowRem;
      stallInc         = 1'b0;
      flushInc         = 1'b0;
      // On the release cycle the shadowed state runs as if never interrupted.
      effState         = (state == MEM_WAIT) ? shadowState : state;
      effRem           = (state == MEM_WAIT) ? shadowRem : rem;

      if (waiting) begin
         hcu.Freeze      = 1'b1;
         hcu.PCWrite     = 1'b0;
         hcu.IF_ID_Write = 1'b0;
         if (state != MEM_WAIT) begin
            shadowStateNext = state;
            shadowRemNext   = rem;
            stateNext       = MEM_WAIT;
         end
      end else if (hcu.BranchControl) begin
         // Taken branch beats load-use and aborts or restarts any sequence.
         hcu.IF_ID_Flush = 1'b1;
         flushInc        = 1'b1;
         if (FLUSH_SLOTS > 1) begin
            stateNext = FLUSH;
            remNext   = FLUSH_RELOAD;
         end else begin
            stateNext = RUN;
            remNext   = '0;
         end
      end else begin
         case (effState)
            RUN: begin
               stateNext = RUN;
               remNext   = '0;
               if (hazard) begin
                  hcu.PCWrite      = 1'b0;
                  hcu.IF_ID_Write  = 1'b0;
                  hcu.ID_EX_Bubble = 1'b1;
                  stallInc         = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     stateNext = LOAD_STALL;
                     remNext   = STALL_RELOAD;
                  end
               end
            end
            LOAD_STALL: begin
               hcu.PCWrite      = 1'b0;
               hcu.IF_ID_Write  = 1'b0;
               hcu.ID_EX_Bubble = 1'b1;
               stallInc         = 1'b1;
               remNext          = (effRem <= REM_ONE) ? '0 : effRem - REM_ONE;
               stateNext        = (effRem <= REM_ONE) ? RUN : LOAD_STALL;
            end
            FLUSH: begin
               hcu.IF_ID_Flush = 1'b1;
               remNext         = (effRem <= REM_ONE) ? '0 : effRem - REM_ONE;
               stateNext       = (effRem <= REM_ONE) ? RUN : FLUSH;
            end
            default: begin
               stateNext = RUN;
               remNext   = '0;
            end
         endcase
      end
   end

   // State, remaining-cycle counter and freeze shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         rem         <= '0;
         shadowState <= RUN;
         shadowRem   <= '0;
      end else begin
         state       <= stateNext;
         rem         <= remNext;
         shadowState <= shadowStateNext;
         shadowRem   <= shadowRemNext;
      end
   end

   hazard_sat_counter #(.W(CNT_W)) stallCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (stallInc),
      .count (hcu.StallCount)
   );

   hazard_sat_counter #(.W(CNT_W)) flushCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (flushInc),
      .count (hcu.FlushCount)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit. Two instances:
//   dutA : LOAD_STALL_CYCLES=2, FLUSH_SLOTS=3, CNT_W=16
//   dutB : LOAD_STALL_CYCLES=3, FLUSH_SLOTS=2, CNT_W=2
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_hazard_control_unit;

   localparam int unsigned RAW = 5;
   localparam bit N = 1'b0;
   localparam bit Y = 1'b1;

   // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze}
   localparam logic [4:0] O_IDLE  = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b00100;
   localparam logic [4:0] O_FLUSH = 5'b11010;
   localparam logic [4:0] O_FRZ   = 5'b00001;

   typedef struct {
      string       name;
      bit          sel;
      bit          chkOut;
      logic [4:0]  out;
      bit          chkCnt;
      int unsigned stallCnt;
      int unsigned flushCnt;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sbq[$];
   int   nTests = 0;
   int   nFail  = 0;

   hazard_control_unit_if #(.REG_ADDR_W(RAW), .CNT_W(16)) ifA ();
   hazard_control_unit_if #(.REG_ADDR_W(RAW), .CNT_W(2))  ifB ();

   hazard_control_unit #(.REG_ADDR_W(RAW), .LOAD_STALL_CYCLES(2), .FLUSH_SLOTS(3), .CNT_W(16)) dutA (
      .clk(clk), .reset(rst), .hcu(ifA)
   );

   hazard_control_unit #(.REG_ADDR_W(RAW), .LOAD_STALL_CYCLES(3), .FLUSH_SLOTS(2), .CNT_W(2)) dutB (
      .clk(clk), .reset(rst), .hcu(ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", nTests, nFail);
      $fatal(1, "watchdog");
   end

   task automatic clearIn();
      ifA.BranchControl = N; ifA.ID_EX_MemRead = N; ifA.ID_EX_RegisterRt = '0;
      ifA.IF_ID_RegisterRs = '0; ifA.IF_ID_RegisterRt = '0; ifA.IF_ID_UsesRt = N;
      ifA.MemReq = N; ifA.MemReady = N;
      ifB.BranchControl = N; ifB.ID_EX_MemRead = N; ifB.ID_EX_RegisterRt = '0;
      ifB.IF_ID_RegisterRs = '0; ifB.IF_ID_RegisterRt = '0; ifB.IF_ID_UsesRt = N;
      ifB.MemReq = N; ifB.MemReady = N;
   endtask

   task automatic setIn(input bit s, input bit br, input bit mr, input logic [4:0] exRt,
                        input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                        input bit mq, input bit my);
      clearIn();
      if (s) begin
         ifB.BranchControl = br; ifB.ID_EX_MemRead = mr; ifB.ID_EX_RegisterRt = exRt;
         ifB.IF_ID_RegisterRs = rs; ifB.IF_ID_RegisterRt = rt; ifB.IF_ID_UsesRt = ur;
         ifB.MemReq = mq; ifB.MemReady = my;
      end else begin
         ifA.BranchControl = br; ifA.ID_EX_MemRead = mr; ifA.ID_EX_RegisterRt = exRt;
         ifA.IF_ID_RegisterRs = rs; ifA.IF_ID_RegisterRt = rt; ifA.IF_ID_UsesRt = ur;
         ifA.MemReq = mq; ifA.MemReady = my;
      end
   endtask

   task automatic expOut(input string nm, input bit s, input logic [4:0] o);
      exp_t e;
      e.name = nm; e.sel = s; e.chkOut = 1'b1; e.out = o;
      e.chkCnt = 1'b0; e.stallCnt = 0; e.flushCnt = 0;
      sbq.push_back(e);
   endtask

   task automatic expCnt(input string nm, input bit s, input int unsigned st, input int unsigned fl);
      exp_t e;
      e.name = nm; e.sel = s; e.chkOut = 1'b0; e.out = '0;
      e.chkCnt = 1'b1; e.stallCnt = st; e.flushCnt = fl;
      sbq.push_back(e);
   endtask

   // One clock cycle: drive inputs, queue the expected controls, advance.
   task automatic cyc(input string nm, input bit s, input bit br, input bit mr,
                      input logic [4:0] exRt, input logic [4:0] rs, input logic [4:0] rt,
                      input bit ur, input bit mq, input bit my, input logic [4:0] o);
      setIn(s, br, mr, exRt, rs, rt, ur, mq, my);
      expOut(nm, s, o);
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples after each falling edge, or just after an async reset.
   initial begin : monitor
      exp_t        e;
      logic [4:0]  actOut;
      int unsigned actSt;
      int unsigned actFl;
      forever begin
         @(negedge clk or posedge rst);
         #1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.sel) begin
               actOut = {ifB.PCWrite, ifB.IF_ID_Write, ifB.ID_EX_Bubble, ifB.IF_ID_Flush, ifB.Freeze};
               actSt  = 32'(ifB.StallCount);
               actFl  = 32'(ifB.FlushCount);
            end else begin
               actOut = {ifA.PCWrite, ifA.IF_ID_Write, ifA.ID_EX_Bubble, ifA.IF_ID_Flush, ifA.Freeze};
               actSt  = 32'(ifA.StallCount);
               actFl  = 32'(ifA.FlushCount);
            end
            if (e.chkOut) begin
               nTests++;
               if (actOut !== e.out) begin
                  nFail++;
                  $display("FAIL %s (dut%s): {PCWrite,IF_ID_Write,Bubble,Flush,Freeze} got %b expected %b",
                           e.name, e.sel ? "B" : "A", actOut, e.out);
               end
            end
            if (e.chkCnt) begin
               nTests++;
               if ((actSt != e.stallCnt) || (actFl != e.flushCnt)) begin
                  nFail++;
                  $display("FAIL %s (dut%s): StallCount/FlushCount got %0d/%0d expected %0d/%0d",
                           e.name, e.sel ? "B" : "A", actSt, actFl, e.stallCnt, e.flushCnt);
               end
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1;
      clearIn();
      @(posedge clk);
      #1;
      expOut("reset_outA", N, O_IDLE); expCnt("reset_cntA", N, 0, 0);
      expOut("reset_outB", Y, O_IDLE); expCnt("reset_cntB", Y, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---------------- dutA: LOAD_STALL_CYCLES=2, FLUSH_SLOTS=3 ----------------
      cyc("idleA",          N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("lu_stall1",      N, N, Y, 5'd8, 5'd8, 5'd0, N, N, N, O_STALL);
      expCnt("lu_cnt1", N, 1, 0);
      cyc("lu_stall2",      N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_STALL);
      expCnt("lu_cnt2", N, 2, 0);
      cyc("lu_done",        N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("reg0_nostall",   N, N, Y, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("rt_unused",      N, N, Y, 5'd9, 5'd3, 5'd9, N, N, N, O_IDLE);
      cyc("rt_used",        N, N, Y, 5'd9, 5'd3, 5'd9, Y, N, N, O_STALL);
      cyc("rt_hold",        N, N, Y, 5'd9, 5'd3, 5'd9, Y, N, N, O_STALL);
      cyc("rehazard1",      N, N, Y, 5'd9, 5'd3, 5'd9, Y, N, N, O_STALL);
      cyc("rehazard2",      N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_STALL);
      expCnt("rehazard_cnt", N, 6, 0);
      cyc("rehazard_done",  N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("br_hazard",      N, Y, Y, 5'd8, 5'd8, 5'd0, N, N, N, O_FLUSH);
      cyc("br_slot2",       N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("br_slot3",       N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      expCnt("br_cnt", N, 6, 1);
      cyc("br_done",        N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("ls_start",       N, N, Y, 5'd8, 5'd8, 5'd0, N, N, N, O_STALL);
      cyc("ls_abort_br",    N, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("fl_slot2",       N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("fl_rebranch",    N, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("fl_re_slot2",    N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("fl_re_slot3",    N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      expCnt("fl_cnt", N, 7, 3);
      cyc("fl_done",        N, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);

      // ---------------- dutB: LOAD_STALL_CYCLES=3, FLUSH_SLOTS=2, CNT_W=2 -------
      expCnt("fz_cnt0", Y, 0, 0);
      cyc("fz_stall1",      Y, N, Y, 5'd8, 5'd8, 5'd0, N, N, N, O_STALL);
      cyc("fz_wait1",       Y, N, N, 5'd0, 5'd0, 5'd0, N, Y, N, O_FRZ);
      expCnt("fz_cnt_frozen", Y, 1, 0);
      cyc("fz_wait2",       Y, N, N, 5'd0, 5'd0, 5'd0, N, Y, N, O_FRZ);
      cyc("fz_wait3",       Y, N, N, 5'd0, 5'd0, 5'd0, N, Y, N, O_FRZ);
      cyc("fz_wait4",       Y, N, N, 5'd0, 5'd0, 5'd0, N, Y, N, O_FRZ);
      cyc("fz_release",     Y, N, N, 5'd0, 5'd0, 5'd0, N, Y, Y, O_STALL);
      cyc("fz_stall3",      Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_STALL);
      expCnt("fz_cnt", Y, 3, 0);
      cyc("fz_done",        Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("fz_over_branch", Y, Y, N, 5'd0, 5'd0, 5'd0, N, Y, N, O_FRZ);
      cyc("fz_br_release",  Y, Y, N, 5'd0, 5'd0, 5'd0, N, Y, Y, O_FLUSH);
      cyc("brB_slot2",      Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      expCnt("brB_cnt", Y, 3, 1);
      cyc("brB_done",       Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);
      cyc("sat_br2",        Y, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("sat_br3",        Y, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      expCnt("sat_cnt_mid", Y, 3, 3);
      cyc("sat_br4",        Y, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);
      cyc("sat_br5",        Y, Y, N, 5'd0, 5'd0, 5'd0, N, N, N, O_FLUSH);

      // Mid-FLUSH: check flushing, then assert reset between clock edges.
      setIn(Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N);
      expOut("midflush", Y, O_FLUSH);
      expCnt("sat_cnt_final", Y, 3, 3);
      #6;
      expOut("async_rst_outB", Y, O_IDLE); expCnt("async_rst_cntB", Y, 0, 0);
      expOut("async_rst_outA", N, O_IDLE); expCnt("async_rst_cntA", N, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expCnt("post_rst_cnt", Y, 0, 0);
      cyc("post_rst",       Y, N, N, 5'd0, 5'd0, 5'd0, N, N, N, O_IDLE);

      @(posedge clk);
      #1;
      nTests++;
      if (sbq.size() != 0) begin
         nFail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage and driving the PC, IF/ID and ID/EX register controls. It adds three things to single-cycle load-use detection: multi-cycle load-use stalls sized to the data-memory load latency, multi-slot branch flushes, and a full-pipeline freeze while data memory is not ready. It also keeps saturating counters of stall cycles and flush events for performance debug.

## Interface
- REG_ADDR_W, 5: register-index width.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (≥1).
- FLUSH_SLOTS, 1: consecutive cycles IF/ID is flushed per taken branch (≥1).
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- BranchControl  in  1  branch resolved taken this cycle.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  REG_ADDR_W  load destination.
- IF_ID_RegisterRs  in  REG_ADDR_W  source rs of the instruction in ID.
- IF_ID_RegisterRt  in  REG_ADDR_W  source rt of the instruction in ID.
- IF_ID_UsesRt  in  1  the instruction in ID actually reads rt.
- MemReq  in  1  MEM stage issues an access this cycle.
- MemReady  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID load enable.
- ID_EX_Bubble  out  1  zero the ID/EX control fields.
- IF_ID_Flush  out  1  replace IF/ID contents with a NOP.
- Freeze  out  1  hold every pipeline register.
- StallCount  out  CNT_W  saturating count of load-stall cycles.
- FlushCount  out  CNT_W  saturating count of taken-branch events.

## Operation
- **Hazard condition:** hazard = ID_EX_MemRead && ID_EX_RegisterRt≠0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRt==IF_ID_RegisterRt)). Register 0 never causes a stall.
- **States:** RUN, LOAD_STALL, FLUSH, MEM_WAIT. A down-counter `rem` (width $clog2(max(LOAD_STALL_CYCLES,FLUSH_SLOTS)+1)) holds the remaining cycles.
- **Priority each cycle:** mem wait > branch > load-use.
- **Mem wait:** MemReq && !MemReady in any state gives Freeze=1, PCWrite=0, IF_ID_Write=0, no flush, no bubble. The state moves to MEM_WAIT, keeping the prior state and `rem` in a shadow register. It stays there until MemReq && MemReady, then returns to the shadowed state with `rem` intact.
- **RUN, BranchControl=1:** IF_ID_Flush=1. FlushCount increments. If FLUSH_SLOTS>1, rem←FLUSH_SLOTS-1 and go to FLUSH.
- **RUN, hazard:** PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. StallCount increments. If LOAD_STALL_CYCLES>1, rem←LOAD_STALL_CYCLES-1 and go to LOAD_STALL.
- **LOAD_STALL:** the same stall outputs are held regardless of the hazard input. rem decrements and the state returns to RUN when rem reaches 0. BranchControl=1 here aborts the stall and is handled exactly as in RUN (the stall outputs are dropped that cycle).
- **FLUSH:** IF_ID_Flush=1. rem decrements and the state returns to RUN when rem reaches 0. A new BranchControl reloads rem to FLUSH_SLOTS-1 and increments FlushCount.
- **Counters:** both saturate at all-ones and never wrap. They increment only on non-frozen cycles.

## Timing
- All control outputs are combinational from the state and the current inputs, so the first stall or flush cycle is the cycle the condition appears. The state and counters update on the rising clk edge.
- Load-use costs exactly LOAD_STALL_CYCLES cycles. A taken branch costs exactly FLUSH_SLOTS cycles, excluding freeze cycles.
- **Reset (async):** state RUN, rem 0, shadow RUN, both counters 0.
- **Outputs with all inputs low:** PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Freeze=0.
- Reset asserted mid-stall, mid-flush or mid-freeze returns these values immediately, without waiting for a clock edge.
- **Simultaneous hazard and branch in RUN:** the flush wins, with no stall and StallCount unchanged.
- **Hazard reappearing on the cycle that LOAD_STALL returns to RUN:** it starts a fresh stall sequence.

## Structure
- **Package hazard_pkg:**
  - state enum (RUN, LOAD_STALL, FLUSH, MEM_WAIT);
  - REG_ZERO constant;
  - a function computing the rem width.
- **Sub-module hazard_sat_counter:** parameter W; ports clk, reset, inc, count. It is instantiated twice, once for StallCount and once for FlushCount.

## Test plan
- **Load-use:** LOAD_STALL_CYCLES=2, ID_EX_MemRead=1, ID_EX_RegisterRt=8, IF_ID_RegisterRs=8 for one cycle, then MemRead=0. Expect PCWrite=0 and ID_EX_Bubble=1 for exactly 2 cycles, then RUN; StallCount=2.
- **Register 0 and unused rt:** ID_EX_RegisterRt=0 matching rs, then rt=9 matching IF_ID_RegisterRt with IF_ID_UsesRt=0. Expect no stall in either case.
- **Multi-slot branch:** FLUSH_SLOTS=3, BranchControl pulsed once. Expect IF_ID_Flush=1 for 3 cycles and FlushCount=1. With a hazard present in the same cycle, expect no stall.
- **Freeze mid-stall:** LOAD_STALL_CYCLES=3; after the first stall cycle, drive MemReq=1, MemReady=0 for 4 cycles. Expect Freeze=1 for those 4 cycles, then 2 more stall cycles; StallCount=3.
- **Counter saturation and reset:** CNT_W=2 with 5 branch events, expect FlushCount=3. Then assert reset asynchronously mid-FLUSH; expect all outputs at their reset values before the next edge.
